// File: rtl/network_sequencer.sv
// Run controller for one bitstream perceptron network: accept a vector, clear, settle, stream, capture, respond.
// Optional macro SEQ_ABORT_EN adds an abort input that cancels an in-flight run.
module network_sequencer #(
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 1,
  parameter int STREAM_LEN  = 256,
  parameter int SETTLE      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  int   req_data   [0:INPUT_SIZE-1],
  output int   net_input  [0:INPUT_SIZE-1],
  output logic net_n_rst,
  output logic net_compute,
  input  int   net_output [0:OUTPUT_SIZE-1],
  output logic resp_valid,
  input  logic resp_ready,
  output int   resp_data  [0:OUTPUT_SIZE-1],
  output logic busy
`ifdef SEQ_ABORT_EN
  ,
  input  logic abort
`endif
);

  localparam int CW = $clog2(STREAM_LEN + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] RUN_LAST    = CW'(STREAM_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_RUN, S_CAPTURE, S_RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          n_rst_q;
  logic          active;
  logic          kill;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign active    = (state == S_CLEAR) || (state == S_SETTLE) ||
                     (state == S_RUN)   || (state == S_CAPTURE);

`ifdef SEQ_ABORT_EN
  // Abort pulls the network into reset in the same cycle it is seen.
  assign kill      = abort & active;
  assign net_n_rst = n_rst_q & ~kill;
`else
  assign kill      = 1'b0;
  assign net_n_rst = n_rst_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      n_rst_q     <= 1'b0;
      net_compute <= 1'b0;
      resp_valid  <= 1'b0;
      net_input   <= '{default: 0};
      resp_data   <= '{default: 0};
    end else if (kill) begin
      state       <= S_IDLE;
      cnt         <= '0;
      n_rst_q     <= 1'b1;
      net_compute <= 1'b0;
      resp_valid  <= 1'b0;
    end else begin
      n_rst_q     <= 1'b1;
      net_compute <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            net_input <= req_data;
            state     <= S_CLEAR;
            cnt       <= '0;
            n_rst_q   <= 1'b0;
          end
        end
        S_CLEAR: begin
          state <= S_SETTLE;
          cnt   <= '0;
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= S_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (cnt == RUN_LAST) begin
            state       <= S_CAPTURE;
            cnt         <= '0;
            net_compute <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          // cnt==0 is the compute cycle; the integrators are read one cycle later.
          if (cnt == '0) begin
            cnt <= CW'(1);
          end else begin
            resp_data  <= net_output;
            resp_valid <= 1'b1;
            state      <= S_RESP;
            cnt        <= '0;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
            cnt        <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_network_sequencer.sv
// Scoreboard bench for network_sequencer: a toy network model presents a value only in the capture window.
module tb_network_sequencer;

  localparam int LAT = 1 + 2 + 256 + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  int   req_data [0:1];
  int   net_input [0:1];
  logic net_n_rst;
  logic net_compute;
  int   net_output [0:0];
  logic resp_valid;
  logic resp_ready = 1'b0;
  int   resp_data [0:0];
  logic busy;
`ifdef SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  int checks = 0;
  int passed = 0;
  int sb [$];
  int cur_model = 0;
  bit hold = 0;

  always #5 clk = ~clk;

  network_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .net_input(net_input), .net_n_rst(net_n_rst), .net_compute(net_compute),
    .net_output(net_output),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy)
`ifdef SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  // Network model: valid value appears after compute and is held through the sampling cycle only.
  always @(negedge clk) begin
    if (net_compute) begin
      net_output[0] = cur_model;
      hold = 1;
    end else if (hold) begin
      hold = 0;
    end else begin
      net_output[0] = 999;
    end
  end

  task automatic start_req(input int a, input int b, input int model);
    @(negedge clk);
    req_data[0] = a;
    req_data[1] = b;
    req_valid = 1'b1;
    cur_model = model;
    sb.push_back(model);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output bit timeout);
    timeout = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (net_n_rst !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || net_compute !== 1'b0)
      $display("FAIL reset_ctrl: n_rst=%b busy=%b rdy=%b rv=%b comp=%b want 0 0 1 0 0", net_n_rst, busy, req_ready, resp_valid, net_compute);
    else passed++;
    checks++;
    if (net_input[0] !== 0 || net_input[1] !== 0 || resp_data[0] !== 0)
      $display("FAIL reset_data: in=%0d,%0d resp=%0d want zeros", net_input[0], net_input[1], resp_data[0]);
    else passed++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (net_n_rst !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: n_rst=%b busy=%b want 1 0", net_n_rst, busy);
    else passed++;
  endtask

  task automatic test_single_run;
    int nlow = 0, ncomp = 0, comp_at = -1, resp_at = -1;
    start_req(128, 64, 77);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!net_n_rst) nlow++;
      if (net_compute) begin ncomp++; comp_at = n; end
      if (resp_valid) begin resp_at = n; break; end
    end
    checks++;
    if (nlow !== 1) $display("FAIL nrst_low_cycles: got %0d want 1", nlow); else passed++;
    checks++;
    if (ncomp !== 1 || comp_at !== LAT - 2)
      $display("FAIL compute_pulse: count %0d at %0d want 1 at %0d", ncomp, comp_at, LAT - 2);
    else passed++;
    checks++;
    if (resp_at !== LAT) $display("FAIL resp_latency: got %0d want %0d", resp_at, LAT); else passed++;
    checks++;
    if (resp_data[0] !== sb[0]) $display("FAIL single_data: got %0d want %0d", resp_data[0], sb[0]); else passed++;
    void'(sb.pop_front());
    checks++;
    if (net_input[0] !== 128 || net_input[1] !== 64)
      $display("FAIL single_input: got %0d,%0d want 128,64", net_input[0], net_input[1]);
    else passed++;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL single_handshake: rv=%b rdy=%b want 0 1", resp_valid, req_ready);
    else passed++;
  endtask

  task automatic test_backpressure;
    bit to;
    int bad = 0;
    start_req(10, 20, 33);
    wait_resp(to);
    checks++;
    if (to) $display("FAIL bp_timeout: no resp_valid got 0 want 1"); else passed++;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid !== 1'b1 || resp_data[0] !== sb[0] || req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) $display("FAIL bp_stable: %0d unstable cycles want 0", bad); else passed++;
    checks++;
    if (resp_data[0] !== sb[0]) $display("FAIL bp_data: got %0d want %0d", resp_data[0], sb[0]); else passed++;
    void'(sb.pop_front());
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL bp_release: rv=%b rdy=%b want 0 1", resp_valid, req_ready);
    else passed++;
  endtask

  task automatic test_busy_requests;
    bit to;
    int bad = 0;
    start_req(128, 64, 90);
    repeat (20) @(negedge clk);
    req_data[0] = 5;
    req_data[1] = 6;
    req_valid = 1'b1;
    to = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (resp_valid) begin to = 0; break; end
      if (net_input[0] !== 128 || net_input[1] !== 64 || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (to || bad !== 0) $display("FAIL busy_ignore: timeout=%0d bad=%0d want 0 0", to, bad); else passed++;
    checks++;
    if (resp_data[0] !== sb[0]) $display("FAIL busy_first_data: got %0d want %0d", resp_data[0], sb[0]); else passed++;
    void'(sb.pop_front());
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || net_input[0] !== 128)
      $display("FAIL busy_idle: rdy=%b in0=%0d want 1 128", req_ready, net_input[0]);
    else passed++;
    cur_model = 44;
    sb.push_back(44);
    @(posedge clk);
    #1 req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || net_input[0] !== 5 || net_input[1] !== 6)
      $display("FAIL busy_accept: busy=%b in=%0d,%0d want 1 5,6", busy, net_input[0], net_input[1]);
    else passed++;
    wait_resp(to);
    checks++;
    if (to || resp_data[0] !== sb[0]) $display("FAIL busy_second_data: got %0d want %0d", resp_data[0], sb[0]); else passed++;
    void'(sb.pop_front());
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    int nresp = 0;
    start_req(200, 100, 12);
    void'(sb.pop_front());
    repeat (3 + 100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || net_n_rst !== 1'b0 || resp_valid !== 1'b0 || net_input[0] !== 0)
      $display("FAIL async_rst: busy=%b n_rst=%b rv=%b in0=%0d want 0 0 0 0", busy, net_n_rst, resp_valid, net_input[0]);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_valid || net_compute) nresp++;
    end
    checks++;
    if (nresp !== 0) $display("FAIL async_no_resp: got %0d active cycles want 0", nresp); else passed++;
  endtask

`ifdef SEQ_ABORT_EN
  task automatic test_abort;
    bit to;
    int ncomp = 0;
    start_req(1, 2, 55);
    wait_resp(to);
    checks++;
    if (to || resp_data[0] !== sb[0]) $display("FAIL abort_pre_data: got %0d want %0d", resp_data[0], sb[0]); else passed++;
    void'(sb.pop_front());
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    start_req(3, 4, 66);
    void'(sb.pop_front());
    repeat (3 + 50) @(negedge clk);
    abort = 1'b1;
    #1;
    checks++;
    if (net_n_rst !== 1'b0) $display("FAIL abort_nrst: got %b want 0", net_n_rst); else passed++;
    @(posedge clk);
    #1 abort = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_idle: busy=%b want 0", busy); else passed++;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (net_compute || resp_valid) ncomp++;
    end
    checks++;
    if (ncomp !== 0 || resp_data[0] !== 55)
      $display("FAIL abort_quiet: active=%0d resp=%0d want 0 55", ncomp, resp_data[0]);
    else passed++;
  endtask
`endif

  initial begin
    req_data = '{0, 0};
    net_output = '{999};
    test_reset();
    test_single_run();
    test_backpressure();
    test_busy_requests();
    test_async_reset();
`ifdef SEQ_ABORT_EN
    test_abort();
`endif
    checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
